// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge: 8N1 serial command stream in, 32-bit single-beat bus
// transactions out, 1- or 4-byte serial reply back.
module uart_bus_bridge #(
  parameter logic [15:0] CLK_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  output logic        tx_out,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic        read_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  // receiver
  logic [1:0]  rx_sync_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_s;

  // transmitter
  logic        tx_busy_q, tx_busy_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic        tx_out_q, tx_out_d;
  logic        tx_last, tx_avail, tx_load;

  // command FSM and bus
  state_t      state_q, state_d;
  logic        op_read_q, op_read_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sel_q, sel_d;
  logic        read_q, read_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [2:0]  resp_left_q, resp_left_d;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_s) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (rx_cnt_q == {1'b0, CLK_DIV[15:1]}) begin
        // a high start-bit sample was a glitch: drop back to idle
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_DATA: if (rx_cnt_q == CLK_DIV) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_STOP: if (rx_cnt_q == CLK_DIV) begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
        rx_valid_d = rx_s;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // tx can take a new byte while idle or during the final stop-bit clock,
  // so reply bytes go out back-to-back
  assign tx_last  = tx_busy_q && (tx_cnt_q == CLK_DIV) && (tx_bit_q == 4'd9);
  assign tx_avail = !tx_busy_q || tx_last;
  assign tx_load  = (state_q == S_RESP) && (resp_left_q != 3'd0) && tx_avail;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    if (tx_load) begin
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shift_d = {1'b1, resp_data_q[7:0]};
      tx_out_d   = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == CLK_DIV) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_out_d  = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_out_d   = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
        end
      end else tx_cnt_d = tx_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_read_d   = op_read_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    read_d      = read_q;
    mask_d      = mask_q;
    resp_data_d = resp_data_q;
    resp_left_d = resp_left_q;
    case (state_q)
      S_CMD: if (rx_valid_q) begin
        if (rx_shift_q == 8'h01 || rx_shift_q == 8'h02) begin
          op_read_d  = rx_shift_q[1];
          byte_cnt_d = '0;
          state_d    = S_ADDR;
        end else begin
          resp_data_d = 32'h0000_00EE;
          resp_left_d = 3'd1;
          state_d     = S_RESP;
        end
      end
      S_ADDR: if (rx_valid_q) begin
        addr_d     = {rx_shift_q, addr_q[31:8]};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) state_d = op_read_q ? S_BUS : S_DATA;
      end
      S_DATA: if (rx_valid_q) begin
        wdata_d    = {rx_shift_q, wdata_q[31:8]};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) state_d = S_BUS;
      end
      S_BUS: if (!sel_q) begin
        sel_d  = 1'b1;
        read_d = op_read_q;
        mask_d = op_read_q ? 4'b0000 : 4'b1111;
      end else if (ready_in) begin
        sel_d       = 1'b0;
        read_d      = 1'b0;
        mask_d      = 4'b0000;
        resp_data_d = op_read_q ? read_value_in : 32'h0000_00AA;
        resp_left_d = op_read_q ? 3'd4 : 3'd1;
        state_d     = S_RESP;
      end
      S_RESP: if (tx_load) begin
        resp_data_d = {8'h00, resp_data_q[31:8]};
        resp_left_d = resp_left_q - 3'd1;
      end else if (resp_left_q == 3'd0 && !tx_busy_q) begin
        state_d = S_CMD;
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_q   <= 2'b11;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_valid_q  <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '1;
      tx_out_q    <= 1'b1;
      state_q     <= S_CMD;
      op_read_q   <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= 1'b0;
      read_q      <= 1'b0;
      mask_q      <= '0;
      resp_data_q <= '0;
      resp_left_q <= '0;
    end else begin
      rx_sync_q   <= {rx_sync_q[0], rx_in};
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      tx_busy_q   <= tx_busy_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_out_q    <= tx_out_d;
      state_q     <= state_d;
      op_read_q   <= op_read_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      read_q      <= read_d;
      mask_q      <= mask_d;
      resp_data_q <= resp_data_d;
      resp_left_q <= resp_left_d;
    end
  end

  assign tx_out          = tx_out_q;
  assign address_out     = addr_q;
  assign write_value_out = wdata_q;
  assign sel_out         = sel_q;
  assign read_out        = read_q;
  assign write_mask_out  = mask_q;

endmodule
